rr_decode_arbiter: RTL and testbench

RR_DECODE_ARBITER -- requirements
Module: rr_decode_arbiter

---
 rtl/rr_decode_arbiter_pkg.sv | 33 +++
 rtl/decoder3to8_l.sv | 18 +
 rtl/rr_decode_arbiter.sv | 96 +++++++++
 tb/tb_rr_decode_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_decode_arbiter_pkg.sv
// Shared types, widths and the round-robin search helper for rr_decode_arbiter.
package rr_decode_arbiter_pkg;

    localparam int unsigned NREQ   = 8;
    localparam int unsigned CODE_W = 3;
    localparam int unsigned CNT_W  = 5;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // First set request bit searching upward from ptr+1, wrapping modulo NREQ.
    function automatic logic [CODE_W-1:0] rr_pick(
        input logic [NREQ-1:0]   req,
        input logic [CODE_W-1:0] ptr
    );
        logic [CODE_W-1:0] v_idx;
        logic [CODE_W-1:0] v_win;
        logic              v_found;
        v_win   = ptr;
        v_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            v_idx = ptr + CODE_W'(i);
            if (!v_found && req[v_idx]) begin
                v_win   = v_idx;
                v_found = 1'b1;
            end
        end
        return v_win;
    endfunction

endpackage

// File: rtl/decoder3to8_l.sv
// Active-low 3-to-8 decoder with enable; all outputs high when disabled.
module decoder3to8_l
    import rr_decode_arbiter_pkg::*;
(
    input  logic              i_en,
    input  logic [CODE_W-1:0] i_code,
    output logic [NREQ-1:0]   o_y_l
);

    // Drive the selected line low only while enabled.
    always_comb begin
        o_y_l = '1;
        if (i_en) begin
            o_y_l[i_code] = 1'b0;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter over 8 requesters with an active-low one-hot grant,
// bounded grant length and a mandatory idle cycle between grants.
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 16
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [NREQ-1:0]   req,
    input  logic              done,
    output logic [CODE_W-1:0] sel,
    output logic [NREQ-1:0]   y_l,
    output logic              valid,
    output logic              timeout
);

    state_t            r_state;
    logic [CODE_W-1:0] r_ptr;
    logic [CODE_W-1:0] r_sel;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_timeout;

    state_t            w_state_nxt;
    logic [CODE_W-1:0] w_ptr_nxt;
    logic [CODE_W-1:0] w_sel_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_timeout_nxt;
    logic [CODE_W-1:0] w_winner;
    logic              w_hold_last;
    logic              w_grant_on;

    assign w_winner    = rr_pick(req, r_ptr);
    assign w_hold_last = (r_cnt == CNT_W'(MAX_HOLD - 1));
    assign w_grant_on  = (r_state == GRANT) && en;

    // State, pointer, grantee code, hold counter and timeout pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= CODE_W'(NREQ - 1);
            r_sel     <= '0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sel     <= w_sel_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    // Next-state logic: grant on any enabled request, release on done,
    // dropped request, disable or hold limit; done wins over the limit.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_sel_nxt     = r_sel;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (en && (req != '0)) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (done || !req[r_sel] || !en || w_hold_last) begin
                    w_state_nxt   = IDLE;
                    w_ptr_nxt     = r_sel;
                    w_timeout_nxt = !done && req[r_sel] && en && w_hold_last;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    decoder3to8_l u_dec (
        .i_en   (w_grant_on),
        .i_code (r_sel),
        .o_y_l  (y_l)
    );

    assign sel     = r_sel;
    assign valid   = w_grant_on;
    assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// Directed and randomized checks of rr_decode_arbiter against a cycle-level
// reference model of the grant rules.
module tb_rr_decode_arbiter;

    localparam int unsigned MAX_HOLD = 4;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [2:0] sel;
    logic [7:0] y_l;
    logic       valid;
    logic       timeout;

    int n_checks;
    int n_errors;

    // Reference model state: who holds the grant and for how many cycles.
    bit m_grant;
    int m_ptr;
    int m_sel;
    int m_held;
    bit m_to;

    rr_decode_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .req     (req),
        .done    (done),
        .sel     (sel),
        .y_l     (y_l),
        .valid   (valid),
        .timeout (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grant = 1'b0;
        m_ptr   = 7;
        m_sel   = 0;
        m_held  = 0;
        m_to    = 1'b0;
    endtask

    // One rising edge worth of arbitration rules, from the sampled inputs.
    task automatic model_edge();
        bit found;
        int c;
        if (rst) begin
            model_reset();
            return;
        end
        m_to = 1'b0;
        if (!m_grant) begin
            if (en && req != 8'h00) begin
                found = 1'b0;
                for (int k = 1; k <= 8; k++) begin
                    c = (m_ptr + k) % 8;
                    if (!found && req[c]) begin
                        m_sel = c;
                        found = 1'b1;
                    end
                end
                m_grant = 1'b1;
                m_held  = 1;
            end
        end else begin
            if (done || !req[m_sel] || !en) begin
                m_grant = 1'b0;
                m_ptr   = m_sel;
            end else if (m_held == MAX_HOLD) begin
                m_grant = 1'b0;
                m_ptr   = m_sel;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [7:0] e_y;
        e_y = 8'hFF;
        if (m_grant && en) e_y[m_sel] = 1'b0;
        chk({tag, ".y_l"}, y_l, e_y);
        chk({tag, ".valid"}, 8'(valid), 8'(m_grant && en));
        chk({tag, ".sel"}, 8'(sel), 8'(m_sel));
        chk({tag, ".timeout"}, 8'(timeout), 8'(m_to));
        chk({tag, ".onehot"}, 8'($countones(~y_l) <= 1), 8'h01);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        tick("rst_pulse");
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        model_reset();

        // Reset state before any clock edge.
        #2;
        check_outputs("reset_async");
        tick("reset_hold");
        rst = 1'b0;
        en  = 1'b1;

        // No requests: nothing granted.
        for (int i = 0; i < 10; i++) tick("no_req");
        chk("no_req_sel_final", 8'(sel), 8'h00);

        // Two requesters: 0 first, then 2 after done and one idle cycle.
        req = 8'b0000_0101;
        tick("r33_g0");
        chk("r33_first_y", y_l, 8'hFE);
        done = 1'b1;
        tick("r33_gap");
        chk("r33_gap_y", y_l, 8'hFF);
        done = 1'b0;
        tick("r33_g2");
        chk("r33_second_y", y_l, 8'hFB);
        chk("r33_second_sel", 8'(sel), 8'h02);
        req = 8'h00;
        tick("r33_drop");
        tick("r33_idle");

        // All requesting, done every grant: strict rotation with gaps.
        reset_pulse();
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            logic [7:0] exp_y;
            exp_y = ~(8'h01 << (k % 8));
            tick("rot_grant");
            chk("rot_y", y_l, exp_y);
            done = 1'b1;
            tick("rot_gap");
            chk("rot_gap_y", y_l, 8'hFF);
            done = 1'b0;
        end

        // Hold limit: requester 3 held without done.
        reset_pulse();
        req = 8'h08;
        for (int i = 0; i < 4; i++) begin
            tick("hold_grant");
            chk("hold_y", y_l, 8'hF7);
        end
        tick("hold_timeout");
        chk("hold_to_pulse", 8'(timeout), 8'h01);
        chk("hold_to_y", y_l, 8'hFF);
        tick("hold_regrant");
        chk("hold_regrant_y", y_l, 8'hF7);
        chk("hold_to_clear", 8'(timeout), 8'h00);

        // Enable dropped mid-grant of requester 5.
        reset_pulse();
        req = 8'h20;
        tick("en_grant5");
        en = 1'b0;
        #1;
        chk("en_drop_y_same_cycle", y_l, 8'hFF);
        chk("en_drop_valid", 8'(valid), 8'h00);
        tick("en_exit");
        en  = 1'b1;
        req = 8'hFF;
        tick("en_next_after_ptr5");
        chk("en_ptr5_next_sel", 8'(sel), 8'h06);

        // Reset between edges during grant of requester 6.
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_mid_y", y_l, 8'hFF);
        chk("rst_mid_valid", 8'(valid), 8'h00);
        chk("rst_mid_timeout", 8'(timeout), 8'h00);
        tick("rst_mid_hold");
        rst = 1'b0;
        req = 8'hC1;
        tick("rst_after");
        chk("rst_after_sel", 8'(sel), 8'h00);
        chk("rst_after_y", y_l, 8'hFE);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) req = 8'($urandom) & 8'($urandom);
            done = ($urandom_range(0, 5) == 0);
            en   = ($urandom_range(0, 15) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            tick("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
